niosii_system_eng_ctrl_out: RTL and testbench
=============================================

# niosii_system_eng_ctrl_out

Avalon-MM write/read slave that drives the 8-bit control bus from the Nios II system into the engine simulator. It is the output-direction counterpart of the engine-simulator input port. Software sets levels through a data register with atomic set/clear aliases. A hardware pulse timer asserts a masked set of bits for an exact number of clock cycles, so injector/ignition strobes do not depend on software latency.

## Interface

Parameters:
- `DATA_W`, default 8: width of `out_port` and of the data/mask registers.
- `CNT_W`, default 16: width of the pulse counter.
- `RESET_VALUE`, default 0: value loaded into the data register on reset.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock. This is the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `address`, in, 3: register select.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe. A write is qualified by `chipselect && !write_n`.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: registered read data.
- `out_port`, out, `DATA_W`: drive to the engine simulator.

## Operation

Register map. Bits above the field width read 0 and are ignored on write.
- 0 DATA (R/W): a write loads `writedata[DATA_W-1:0]`. A read returns the current `out_port` value, including any active pulse bits.
- 2 PMASK (R/W): selects the bits forced high while a pulse is active.
- 3 PCNT (R/W):
  - A write loads the counter with `writedata[CNT_W-1:0]`.
  - A read returns the remaining count.
- 4 OUTSET (W): DATA <= DATA | wd.
- 5 OUTCLR (W): DATA <= DATA & ~wd.
- 1, 6 and 7 read 0. Writes to them are ignored. Reads of 4 and 5 return 0.

Output and pulse behaviour:
- `out_port = DATA | (busy ? PMASK : 0)`, where `busy = (PCNT != 0)`. `out_port` is decoded from flops only; there is no combinational path from bus inputs.
- PCNT decrements by 1 on every clock while it is nonzero and no PCNT write occurs. It saturates at 0.
- Writing PCNT while busy reloads the counter (retrigger).
- Writing 0 to PCNT aborts the pulse immediately.
- Writes to DATA, OUTSET or OUTCLR during a pulse update DATA. The pulse continues.
- Writing PMASK during a pulse takes effect on the next cycle.
- A pulse never clears DATA bits. When the pulse ends, `out_port` returns to DATA.

State:
- The block has two states, IDLE (PCNT == 0) and PULSE (PCNT != 0).
- IDLE -> PULSE on a PCNT write of a nonzero value.
- PULSE -> IDLE when PCNT decrements from 1 to 0, or on a PCNT write of 0.

## Timing

Reset values:
- DATA = `RESET_VALUE`.
- PMASK = 0, PCNT = 0.
- `readdata` = 0.
- `out_port` = `RESET_VALUE`.

Bus timing:
- Reset mid-pulse ends the pulse on the same edge.
- Writes take zero wait states.
- Register updates occur on the edge that samples the write. `out_port` reflects a write in the following cycle.
- Reads have 1-cycle latency: `readdata` is registered every cycle from the `address` mux, unconditionally.

Pulse length:
- A PCNT write of N sampled at edge E0 holds PMASK bits high for exactly N cycles after E0. They drop on edge E0+N.
- N = 2^CNT_W-1 must work without wrap-around.

## Configuration

- `ENG_CTRL_OUT_PULSE_EN` defined: the PMASK/PCNT pulse timer is compiled in as described above.
- Macro undefined: no counter or mask flops are built.
  - Addresses 2 and 3 read 0 and writes to them are ignored.
  - `out_port = DATA` always.
  - All other behaviour is unchanged.

## Test plan

- Reset, then read addresses 0–7. Required: `out_port = RESET_VALUE`. All reads return 0, except address 0, which returns `RESET_VALUE`.
- Write DATA = 0x5A, OUTSET 0x81, OUTCLR 0x10. Required: `out_port` goes 0x5A, then 0xDB, then 0xCB. Each value appears one cycle after its write. A read of address 0 returns 0xCB.
- With DATA = 0x01 and PMASK = 0xF0, write PCNT = 5. Required: `out_port` = 0xF1 for exactly 5 cycles, then 0x01. PCNT reads 4, 3, 2, 1, 0 on successive cycles.
- Retrigger and abort:
  - Write PCNT = 10, then PCNT = 3 at cycle 4. Required: a total high time of 4 + 3 = 7 cycles.
  - Write PCNT = 8, then PCNT = 0 at cycle 2. Required: mask bits drop on the next edge.
- Assert `reset` at cycle 3 of a PCNT = 100 pulse while DATA = 0x3C. Required: next cycle `out_port = RESET_VALUE`, PCNT = 0, PMASK = 0.
- Build with the macro undefined, write PCNT = 5 with PMASK = 0xFF. Required: `out_port` unchanged. Reads of addresses 2 and 3 return 0.

Source files
------------

// File: rtl/niosii_system_eng_ctrl_out_if.sv
// Avalon-MM slave bus bundle for the engine-control output port.
interface niosii_system_eng_ctrl_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/niosii_system_eng_ctrl_out.sv
// Engine-simulator control output: DATA register with set/clear aliases plus an
// optional cycle-exact pulse timer (enabled by ENG_CTRL_OUT_PULSE_EN).
module niosii_system_eng_ctrl_out #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       CNT_W       = 16,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  niosii_system_eng_ctrl_out_if.slave    bus,
  output logic [DATA_W-1:0]              out_port
);
  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_PMASK  = 3'd2;
  localparam logic [2:0] A_PCNT   = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;

  logic              wr_c;
  logic [DATA_W-1:0] wd_c;
  logic              unused_wd;

  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic [BUS_W-1:0]  readdata_q, readdata_d;

  assign wr_c      = bus.chipselect && !bus.write_n;
  assign wd_c      = bus.writedata[DATA_W-1:0];
  assign unused_wd = ^bus.writedata;

  // DATA register with direct, set and clear write aliases
  always_comb begin
    data_d = data_q;
    if (wr_c) begin
      case (bus.address)
        A_DATA:   data_d = wd_c;
        A_OUTSET: data_d = data_q | wd_c;
        A_OUTCLR: data_d = data_q & ~wd_c;
        default:  data_d = data_q;
      endcase
    end
  end

`ifdef ENG_CTRL_OUT_PULSE_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] PULSE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] pmask_q, pmask_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic              pcnt_wr_c;
  logic [CNT_W-1:0]  wc_c;

  assign pcnt_wr_c = wr_c && (bus.address == A_PCNT);
  assign wc_c      = bus.writedata[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pmask_q <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pmask_q <= pmask_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Pulse timer: a PCNT write always wins over the decrement (retrigger/abort)
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    pmask_d = pmask_q;
    if (wr_c && (bus.address == A_PMASK)) pmask_d = wd_c;
    case (state_q)
      IDLE: begin
        if (pcnt_wr_c) begin
          pcnt_d  = wc_c;
          state_d = (wc_c != '0) ? PULSE : IDLE;
        end
      end
      PULSE: begin
        if (pcnt_wr_c) begin
          pcnt_d  = wc_c;
          state_d = (wc_c != '0) ? PULSE : IDLE;
        end else begin
          pcnt_d  = pcnt_q - CNT_W'(1);
          state_d = (pcnt_q == CNT_W'(1)) ? IDLE : PULSE;
        end
      end
      default: begin
        state_d = IDLE;
        pcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    out_port_d = data_d | ((state_d == PULSE) ? pmask_d : '0);
    case (bus.address)
      A_DATA:  readdata_d = BUS_W'(out_port_q);
      A_PMASK: readdata_d = BUS_W'(pmask_q);
      A_PCNT:  readdata_d = BUS_W'(pcnt_q);
      default: readdata_d = '0;
    endcase
  end
`else
  always_comb begin
    out_port_d = data_d;
    readdata_d = (bus.address == A_DATA) ? BUS_W'(out_port_q) : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      out_port_q <= RESET_VALUE;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      out_port_q <= out_port_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port     = out_port_q;
  assign bus.readdata = readdata_q;
endmodule

// File: tb/tb_niosii_system_eng_ctrl_out.sv
// Randomized + directed bench for niosii_system_eng_ctrl_out against a register-level model.
module tb_niosii_system_eng_ctrl_out;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_port;
  int         checks = 0;
  int         errors = 0;
  int         hi_cycles = 0;

  // Model: register contents as plain integers
  int m_data, m_mask, m_cnt;
  int exp_rd, exp_out;

  niosii_system_eng_ctrl_out_if bus ();

  niosii_system_eng_ctrl_out #(.DATA_W(8), .CNT_W(16), .RESET_VALUE(RV)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

`ifdef ENG_CTRL_OUT_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  function automatic int model_out();
    return (m_cnt > 0) ? (m_data | m_mask) : m_data;
  endfunction

  function automatic int model_read(input int a);
    case (a)
      0: return model_out();
      2: return PULSE_EN ? m_mask : 0;
      3: return PULSE_EN ? m_cnt : 0;
      default: return 0;
    endcase
  endfunction

  task automatic step(input bit rst, input bit cs, input bit wn, input int a,
                      input logic [31:0] wd, input string tag);
    bit cnt_written;
    reset          = rst;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = 3'(a);
    bus.writedata  = wd;
    @(posedge clk);
    cnt_written = 1'b0;
    if (rst) begin
      m_data = int'(RV); m_mask = 0; m_cnt = 0; exp_rd = 0;
    end else begin
      exp_rd = model_read(a);
      if (cs && !wn) begin
        case (a)
          0: m_data = int'(wd[7:0]);
          2: if (PULSE_EN) m_mask = int'(wd[7:0]);
          3: if (PULSE_EN) begin m_cnt = int'(wd[15:0]); cnt_written = 1'b1; end
          4: m_data = m_data | int'(wd[7:0]);
          5: m_data = m_data & ~int'(wd[7:0]) & 255;
          default: ;
        endcase
      end
      if (!cnt_written && m_cnt > 0) m_cnt = m_cnt - 1;
    end
    exp_out = model_out();
    #1;
    if ((out_port & 8'hF0) == 8'hF0) hi_cycles++;
    checks++;
    assert (bus.readdata === 32'(exp_rd))
      else begin errors++; $error("FAIL %s readdata got %h exp %h", tag, bus.readdata, 32'(exp_rd)); end
    checks++;
    assert (out_port === 8'(exp_out))
      else begin errors++; $error("FAIL %s out_port got %h exp %h", tag, out_port, 8'(exp_out)); end
  endtask

  task automatic wr(input int a, input logic [31:0] wd, input string tag);
    step(1'b0, 1'b1, 1'b0, a, wd, tag);
  endtask

  task automatic rd(input int a, input string tag);
    step(1'b0, 1'b1, 1'b1, a, 32'h0, tag);
  endtask

  initial begin
    int a, exp_hi;
    reset = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.address = '0; bus.writedata = '0;
    m_data = int'(RV); m_mask = 0; m_cnt = 0;

    step(1'b1, 1'b0, 1'b1, 0, 32'h0, "reset");
    step(1'b1, 1'b0, 1'b1, 0, 32'h0, "reset");
    for (int i = 0; i < 8; i++) rd(i, "reset_read");
    rd(0, "reset_read_tail");

    wr(0, 32'hFFFF_FF5A, "data_wr");
    wr(4, 32'h0000_0081, "outset");
    wr(5, 32'h0000_0010, "outclr");
    rd(0, "data_rd");
    rd(0, "data_rd2");

    wr(0, 32'h01, "pulse_data");
    wr(2, 32'hF0, "pulse_mask");
    wr(3, 32'd5, "pulse5");
    for (int i = 0; i < 7; i++) rd(3, "pulse5_cnt");

    hi_cycles = 0;
    wr(3, 32'd10, "retrig10");
    for (int i = 0; i < 3; i++) rd(3, "retrig_run");
    wr(3, 32'd3, "retrig3");
    for (int i = 0; i < 6; i++) rd(3, "retrig_tail");
    exp_hi = PULSE_EN ? 7 : 0;
    checks++;
    assert (hi_cycles === exp_hi)
      else begin errors++; $error("FAIL retrig_len got %0d exp %0d", hi_cycles, exp_hi); end

    wr(3, 32'd8, "abort8");
    rd(3, "abort_run");
    wr(3, 32'd0, "abort0");
    rd(3, "abort_after");
    rd(0, "abort_after0");

    wr(0, 32'h3C, "rst_data");
    wr(3, 32'd100, "rst_pulse");
    rd(3, "rst_run"); rd(3, "rst_run");
    step(1'b1, 1'b0, 1'b1, 0, 32'h0, "mid_reset");
    rd(2, "post_rst_mask");
    rd(3, "post_rst_cnt");
    rd(0, "post_rst_data");

    wr(2, 32'hFF, "full_mask");
    wr(3, 32'd5, "full_pulse");
    rd(2, "full_rd_mask");
    rd(3, "full_rd_cnt");

    wr(2, 32'h0C, "max_mask");
    wr(3, 32'hFFFF_FFFF, "max_cnt");
    for (int i = 0; i < 65536; i++) rd(3, "max_run");

    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 1'b0, 1'b1, a, 32'h0, "rnd_reset");
      else
        step(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0, a,
             (a == 3) ? 32'($urandom_range(0, 12)) | ($urandom & 32'hFFFF_0000) : $urandom,
             "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
